// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the SPI master: FSM state encoding, SPI mode
//   constants (mode 0) and a helper that tells whether a state drives the
//   slave select low.
//   No ports (package).
package spi_pkg;

    // SPI mode 0: sclk idles low; data is sampled on the leading (rising) edge
    // and shifted on the trailing (falling) edge.
    localparam logic MODE_CPOL = 1'b0;
    localparam logic MODE_CPHA = 1'b0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SETUP = S_SETUP,
        ST_HIGH  = S_HIGH,
        ST_LOW   = S_LOW,
        ST_HOLD  = S_HOLD,
        ST_GAP   = S_GAP
    } state_t;

    // True for every state in which the slave is selected.
    function automatic logic is_select(input state_t s);
        return (s == ST_SETUP) || (s == ST_HIGH) || (s == ST_LOW) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
//   Half-period tick generator. While en is high, counts clk cycles and
//   raises tick on the last cycle of every CLK_DIV-cycle half period. The
//   count is held at zero while en is low so the first half period after
//   enabling is always full length.
// Ports
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   en     in  count enable
//   tick   out last cycle of the current half period (combinational)
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// spi_master
//   Single-clock SPI master, mode 0, full duplex, MSB first.
//
//   state | meaning
//   IDLE  | waiting for start, ss_n high, busy low
//   SETUP | ss_n low, sclk low, MSB presented on mosi
//   HIGH  | sclk high; miso captured on entry
//   LOW   | sclk low; mosi advanced on entry
//   HOLD  | sclk low after the last bit, ss_n still low
//   GAP   | ss_n high recovery time, busy still high
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   start    in   transfer request, taken only in IDLE
//   tx_data  in   word to send, latched when start is taken
//   busy     out  transfer in progress (including the GAP recovery)
//   done     out  one-cycle pulse, rx_data updated
//   rx_data  out  last received word
//   ss_n     out  slave select, active low
//   sclk     out  SPI clock
//   mosi     out  serial data out
//   miso     in   serial data in (assumed synchronous to clk)
module spi_master
    import spi_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] tx_data,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] rx_data,
    output logic            ss_n,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso
);
    localparam int BW = $clog2(BITS + 1);

    state_t          state, state_nxt;
    logic            tick;
    logic            accept, lead_edge, trail_edge, capture, advance;
    logic [BW-1:0]   bit_cnt;
    logic [BITS-1:0] tx_sr, rx_sr;
    logic            ss_n_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: if (tick)  state_nxt = ST_HIGH;
            // bit_cnt already counts the rising edge that entered this HIGH
            ST_HIGH:  if (tick)  state_nxt = (bit_cnt == BW'(BITS)) ? ST_HOLD : ST_LOW;
            ST_LOW:   if (tick)  state_nxt = ST_HIGH;
            ST_HOLD:  if (tick)  state_nxt = ST_GAP;
            ST_GAP:   if (tick)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        accept     = (state == ST_IDLE) && start;
        lead_edge  = (state != ST_HIGH) && (state_nxt == ST_HIGH);
        trail_edge = (state == ST_HIGH) && (state_nxt == ST_LOW);
        // Mode 0 samples on the leading edge and shifts on the trailing edge.
        capture    = (MODE_CPHA == 1'b0) ? lead_edge  : trail_edge;
        advance    = (MODE_CPHA == 1'b0) ? trail_edge : lead_edge;

        ss_n_nxt = !is_select(state_nxt);
        sclk_nxt = (state_nxt == ST_HIGH) ^ MODE_CPOL;
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state == ST_HOLD) && (state_nxt == ST_GAP);

        if (!is_select(state_nxt)) begin
            mosi_nxt = 1'b0;
        end else if (accept) begin
            mosi_nxt = tx_data[BITS-1];
        end else if (advance) begin
            mosi_nxt = tx_sr[BITS-2];
        end else begin
            mosi_nxt = tx_sr[BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            ss_n    <= 1'b1;
            sclk    <= MODE_CPOL;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            ss_n  <= ss_n_nxt;
            sclk  <= sclk_nxt;
            mosi  <= mosi_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;

            if (accept) begin
                tx_sr   <= tx_data;
                bit_cnt <= '0;
            end else if (advance) begin
                tx_sr <= {tx_sr[BITS-2:0], 1'b0};
            end

            if (capture) begin
                rx_sr   <= {rx_sr[BITS-2:0], miso};
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (done_nxt) begin
                rx_data <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
//   Self-checking bench for spi_master. Instance a: BITS=8, CLK_DIV=2 with a
//   mode-0 slave model or mosi->miso loopback. Instance b: BITS=16,
//   CLK_DIV=1 in loopback.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, busy_a, done_a, ss_n_a, sclk_a, mosi_a, miso_a;
    logic [7:0]  tx_a, rx_a;
    logic        start_b, busy_b, done_b, ss_n_b, sclk_b, mosi_b, miso_b;
    logic [15:0] tx_b, rx_b;

    logic        loop_a;
    logic [7:0]  s_ret;
    logic [7:0]  s_sr = 8'h00;
    logic [7:0]  s_rx = 8'h00;

    assign miso_a = loop_a ? mosi_a : s_sr[7];
    assign miso_b = mosi_b;

    spi_master #(.BITS(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .ss_n(ss_n_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master #(.BITS(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .ss_n(ss_n_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    int checks = 0;
    int errors = 0;

    // Slave model and bus monitor for instance a, sampled on negedge clk.
    int   lo_run_a = 0, hi_run_a = 0, lo_last_a = 0, hi_last_a = 0;
    int   rise_a = 0, rise_idle_a = 0, done_cyc_a = 0;
    logic ss_prev_a = 1'b1, sclk_prev_a = 1'b0;

    always @(negedge clk) begin
        if (ss_n_a) begin
            s_sr = s_ret;
        end else begin
            if (sclk_a && !sclk_prev_a) s_rx = {s_rx[6:0], mosi_a};
            if (!sclk_a && sclk_prev_a) s_sr = {s_sr[6:0], 1'b0};
        end
        if (sclk_a && !sclk_prev_a) begin
            rise_a++;
            if (ss_n_a) rise_idle_a++;
        end
        if (done_a) done_cyc_a++;
        if (ss_n_a == ss_prev_a) begin
            if (ss_n_a) hi_run_a++;
            else        lo_run_a++;
        end else if (ss_n_a) begin
            lo_last_a = lo_run_a;
            hi_run_a  = 1;
        end else begin
            hi_last_a = hi_run_a;
            lo_run_a  = 1;
        end
        ss_prev_a   = ss_n_a;
        sclk_prev_a = sclk_a;
    end

    // Monitor for instance b.
    int   lo_run_b = 0, lo_last_b = 0, rise_b = 0;
    logic ss_prev_b = 1'b1, sclk_prev_b = 1'b0;

    always @(negedge clk) begin
        if (sclk_b && !sclk_prev_b) rise_b++;
        if (!ss_n_b) lo_run_b++;
        else if (!ss_prev_b) begin
            lo_last_b = lo_run_b;
            lo_run_b  = 0;
        end
        ss_prev_b   = ss_n_b;
        sclk_prev_b = sclk_b;
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] ret;
        logic       loopback;
        logic [7:0] rx;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         r0, d0;
    bit         ok;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_rx_a();
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check("rx_data", {24'h0, rx_a}, {24'h0, e});
        end
    endtask

    task automatic wait_done_a(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done_b(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done_b) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle_a();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (!busy_a) begin
                seen = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'h0, seen}, 1);
    endtask

    // Returns one step after the negedge of the first selected cycle.
    task automatic start_pulse_a(input logic [7:0] tx);
        @(negedge clk);
        start_a = 1'b1;
        tx_a    = tx;
        @(negedge clk); #1;
        start_a = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{tx: 8'hA5, ret: 8'h00, loopback: 1'b1, rx: 8'hA5};
        vecs[1] = '{tx: 8'hC3, ret: 8'h3C, loopback: 1'b0, rx: 8'h3C};
        vecs[2] = '{tx: 8'h00, ret: 8'hFF, loopback: 1'b0, rx: 8'hFF};
        vecs[3] = '{tx: 8'hFF, ret: 8'h00, loopback: 1'b0, rx: 8'h00};
        vecs[4] = '{tx: 8'h5A, ret: 8'h96, loopback: 1'b0, rx: 8'h96};
        vecs[5] = '{tx: 8'h81, ret: 8'h7E, loopback: 1'b1, rx: 8'h81};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        tx_a = 8'h00; tx_b = 16'h0000; loop_a = 1'b0; s_ret = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ss_n", {31'h0, ss_n_a}, 1);
        check("rst_sclk", {31'h0, sclk_a}, 0);
        check("rst_mosi", {31'h0, mosi_a}, 0);
        check("rst_busy", {31'h0, busy_a}, 0);
        check("rst_done", {31'h0, done_a}, 0);
        check("rst_rx",   {24'h0, rx_a}, 0);
        rst_n = 1'b1;

        // Table: loopback and slave-model transfers.
        for (int i = 0; i < 6; i++) begin
            wait_idle_a();
            s_ret  = vecs[i].ret;
            loop_a = vecs[i].loopback;
            r0 = rise_a;
            d0 = done_cyc_a;
            exp_q.push_back(vecs[i].rx);
            start_pulse_a(vecs[i].tx);
            check("start_busy", {31'h0, busy_a}, 1);
            check("start_ss_n", {31'h0, ss_n_a}, 0);
            check("start_mosi_msb", {31'h0, mosi_a}, {31'h0, vecs[i].tx[7]});
            wait_done_a(ok);
            check("done_seen", {31'h0, ok}, 1);
            check_rx_a();
            check("slave_capture", {24'h0, s_rx}, {24'h0, vecs[i].tx});
            check("ss_low_cycles", lo_last_a, 34);
            check("sclk_rises", rise_a - r0, 8);
            @(negedge clk); #1;
            check("done_width", done_cyc_a - d0, 1);
        end

        // Start re-pulsed mid-transfer must be ignored.
        wait_idle_a();
        s_ret = 8'h55; loop_a = 1'b0;
        r0 = rise_a; d0 = done_cyc_a;
        exp_q.push_back(8'h55);
        start_pulse_a(8'h3C);
        repeat (9) @(negedge clk);
        start_a = 1'b1; tx_a = 8'hFF;
        @(negedge clk); #1;
        start_a = 1'b0;
        wait_done_a(ok);
        check("busy_start_done_seen", {31'h0, ok}, 1);
        check_rx_a();
        check("busy_start_capture", {24'h0, s_rx}, 8'h3C);
        repeat (60) @(negedge clk);
        #1;
        check("busy_start_done_count", done_cyc_a - d0, 1);
        check("busy_start_rises", rise_a - r0, 8);
        check("busy_start_idle", {31'h0, busy_a}, 0);

        // Reset in the middle of a transfer.
        d0 = done_cyc_a;
        start_pulse_a(8'hE7);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("abort_ss_n", {31'h0, ss_n_a}, 1);
        check("abort_sclk", {31'h0, sclk_a}, 0);
        check("abort_busy", {31'h0, busy_a}, 0);
        check("abort_rx",   {24'h0, rx_a}, 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        check("abort_no_done", done_cyc_a - d0, 0);

        // Start held high: back-to-back words.
        loop_a = 1'b1;
        r0 = rise_a;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        @(negedge clk);
        start_a = 1'b1; tx_a = 8'h01;
        wait_done_a(ok);
        check("b2b_done1_seen", {31'h0, ok}, 1);
        check_rx_a();
        tx_a = 8'h80;
        wait_done_a(ok);
        start_a = 1'b0;
        check("b2b_done2_seen", {31'h0, ok}, 1);
        check_rx_a();
        check("b2b_gap_cycles", hi_last_a, 3);
        check("b2b_rises", rise_a - r0, 16);
        check("b2b_capture", {24'h0, s_rx}, 8'h80);
        wait_idle_a();

        // 16-bit word at the fastest divider.
        r0 = rise_b;
        @(negedge clk);
        start_b = 1'b1; tx_b = 16'hBEEF;
        @(negedge clk); #1;
        start_b = 1'b0;
        check("w16_busy", {31'h0, busy_b}, 1);
        wait_done_b(ok);
        check("w16_done_seen", {31'h0, ok}, 1);
        check("w16_rx", {16'h0, rx_b}, 16'hBEEF);
        check("w16_ss_low_cycles", lo_last_b, 33);
        check("w16_rises", rise_b - r0, 16);

        check("sclk_while_deselected", rise_idle_a, 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
